// File: rtl/serial_subtractor.sv
// serial_subtractor: multi-cycle a - b - borrow_in, BITS_PER_CYCLE bits per clock, LSB slice first
// with a registered borrow between slices and a start/busy/done handshake.
module serial_subtractor #(
    parameter int WIDTH = 8,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             overflow
);
    localparam int BPC = BITS_PER_CYCLE;
    localparam int S = WIDTH / BPC;
    localparam int CW = S > 1 ? $clog2(S) : 1;

    if (WIDTH < 2 || WIDTH % BPC != 0) begin : g_bad_params
        $fatal(1, "serial_subtractor: BITS_PER_CYCLE must divide WIDTH and WIDTH must be >= 2");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] sa, sb, res, nres;
    logic [CW-1:0]    cnt;
    logic             brw, bout, bmsb;
    logic [BPC-1:0]   sd;

    // Ripple full-subtractor cells across one slice; returns {borrow out, borrow into slice MSB, diff bits}.
    function automatic logic [BPC+1:0] slice(input logic [BPC-1:0] x, input logic [BPC-1:0] y, input logic bi);
        logic [BPC-1:0] d;
        logic c, cm;
        c = bi;
        cm = bi;
        for (int i = 0; i < BPC; i++) begin
            cm = c;
            d[i] = x[i] ^ y[i] ^ c;
            c = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & c);
        end
        return {c, cm, d};
    endfunction

    always_comb begin
        {bout, bmsb, sd} = slice(sa[BPC-1:0], sb[BPC-1:0], brw);
        nres = (WIDTH'(sd) << (WIDTH - BPC)) | (res >> BPC);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
            overflow   <= 1'b0;
            brw        <= 1'b0;
            cnt        <= '0;
            sa         <= '0;
            sb         <= '0;
            res        <= '0;
        end else begin
            case (state)
                RUN: begin
                    sa  <= sa >> BPC;
                    sb  <= sb >> BPC;
                    brw <= bout;
                    res <= nres;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(S - 1)) begin
                        diff       <= nres;
                        borrow_out <= bout;
                        overflow   <= bmsb ^ bout;
                        done       <= 1'b1;
                        busy       <= 1'b0;
                        state      <= DONE;
                    end
                end
                default: begin
                    done <= 1'b0;
                    if (start) begin
                        sa    <= a;
                        sb    <= b;
                        brw   <= borrow_in;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed and random checks of serial_subtractor against
// a plain-arithmetic reference, using an 8-bit instance and four 16-bit instances.
module tb_serial_subtractor;
    logic clk = 0, rst = 1, start = 0, bin = 0;
    logic [7:0] a = 0, b = 0, diff;
    logic busy, done, borrow_out, overflow;

    logic s16 = 0, bin16 = 0;
    logic [15:0] a16 = 0, b16 = 0;
    logic bz16[4], dn16[4], bo16[4], ov16[4];
    logic [15:0] d16[4];
    int bpc16[4] = '{1, 2, 4, 16};

    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8), .BITS_PER_CYCLE(1)) dut8 (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .borrow_in(bin),
        .busy(busy), .done(done), .diff(diff), .borrow_out(borrow_out), .overflow(overflow));
    serial_subtractor #(.WIDTH(16), .BITS_PER_CYCLE(1)) dut16_1 (
        .clk(clk), .rst(rst), .start(s16), .a(a16), .b(b16), .borrow_in(bin16),
        .busy(bz16[0]), .done(dn16[0]), .diff(d16[0]), .borrow_out(bo16[0]), .overflow(ov16[0]));
    serial_subtractor #(.WIDTH(16), .BITS_PER_CYCLE(2)) dut16_2 (
        .clk(clk), .rst(rst), .start(s16), .a(a16), .b(b16), .borrow_in(bin16),
        .busy(bz16[1]), .done(dn16[1]), .diff(d16[1]), .borrow_out(bo16[1]), .overflow(ov16[1]));
    serial_subtractor #(.WIDTH(16), .BITS_PER_CYCLE(4)) dut16_4 (
        .clk(clk), .rst(rst), .start(s16), .a(a16), .b(b16), .borrow_in(bin16),
        .busy(bz16[2]), .done(dn16[2]), .diff(d16[2]), .borrow_out(bo16[2]), .overflow(ov16[2]));
    serial_subtractor #(.WIDTH(16), .BITS_PER_CYCLE(16)) dut16_16 (
        .clk(clk), .rst(rst), .start(s16), .a(a16), .b(b16), .borrow_in(bin16),
        .busy(bz16[3]), .done(dn16[3]), .diff(d16[3]), .borrow_out(bo16[3]), .overflow(ov16[3]));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Exact integer subtraction, then reduce: modulo result, unsigned borrow, signed range overflow.
    function automatic void ref_sub(input int w, input int av, input int bv, input int bi,
                                    output logic [15:0] d, output logic bo, output logic ov);
        int r, h, sa, sb, sr;
        h = 1 << (w - 1);
        r = av - bv - bi;
        d = 16'(r & ((1 << w) - 1));
        bo = r < 0;
        sa = av >= h ? av - 2 * h : av;
        sb = bv >= h ? bv - 2 * h : bv;
        sr = sa - sb - bi;
        ov = sr < -h || sr >= h;
    endfunction

    task automatic go8(input int av, input int bv, input int bi, input bit mid);
        logic [15:0] ed;
        logic eb, eo, held;
        logic [7:0] pd;
        int nd, nb;
        ref_sub(8, av, bv, bi, ed, eb, eo);
        pd = diff;
        held = 1;
        nd = 0;
        nb = 0;
        a = 8'(av);
        b = 8'(bv);
        bin = bi[0];
        start = 1;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            start = 0;
            if (n == 1) begin
                a = 8'($urandom);
                b = 8'($urandom);
                bin = 1'($urandom);
            end
            if (mid && n == 3) begin
                start = 1;
                a = 8'hFF;
                b = 8'h00;
                bin = 0;
            end
            if (busy) nb++;
            if (done) begin
                nd = n;
                break;
            end
            if (diff !== pd) held = 0;
        end
        chk("latency8", 64'(nd - 1), 64'd8);
        chk("busy_cycles8", 64'(nb), 64'd8);
        chk("hold8", 64'(held), 64'd1);
        chk("diff8", 64'(diff), 64'(ed[7:0]));
        chk("borrow8", 64'(borrow_out), 64'(eb));
        chk("ovf8", 64'(overflow), 64'(eo));
        @(negedge clk);
        chk("done_pulse8", {62'd0, done, busy}, 64'd0);
    endtask

    task automatic go16(input int av, input int bv, input int bi);
        logic [15:0] ed;
        logic eb, eo;
        int nd[4];
        ref_sub(16, av, bv, bi, ed, eb, eo);
        nd = '{0, 0, 0, 0};
        a16 = 16'(av);
        b16 = 16'(bv);
        bin16 = bi[0];
        s16 = 1;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            s16 = 0;
            if (n == 1) begin
                a16 = 16'($urandom);
                b16 = 16'($urandom);
                bin16 = 1'($urandom);
            end
            for (int j = 0; j < 4; j++) if (dn16[j] && nd[j] == 0) nd[j] = n;
        end
        for (int j = 0; j < 4; j++) begin
            chk($sformatf("latency16_bpc%0d", bpc16[j]), 64'(nd[j] - 1), 64'(16 / bpc16[j]));
            chk($sformatf("diff16_bpc%0d", bpc16[j]), 64'(d16[j]), 64'(ed));
            chk($sformatf("borrow16_bpc%0d", bpc16[j]), 64'(bo16[j]), 64'(eb));
            chk($sformatf("ovf16_bpc%0d", bpc16[j]), 64'(ov16[j]), 64'(eo));
        end
    endtask

    initial begin
        int t1, t2, nd;
        logic [7:0] d1, d2;
        logic bo2;
        repeat (3) @(negedge clk);
        chk("reset8", {59'd0, busy, done, borrow_out, overflow, |diff}, 64'd0);
        chk("reset16", {59'd0, bz16[3], dn16[3], bo16[3], ov16[3], |d16[3]}, 64'd0);
        rst = 0;
        @(negedge clk);

        go8(8'h5A, 8'h3C, 0, 0);
        chk("diff_5a_3c", 64'(diff), 64'h1E);
        go8(8'h00, 8'h01, 0, 0);
        chk("diff_00_01", {55'd0, diff, borrow_out}, {55'd0, 8'hFF, 1'b1});
        go8(8'h80, 8'h01, 0, 0);
        chk("ovf_80_01", {55'd0, diff, overflow}, {55'd0, 8'h7F, 1'b1});
        go8(8'h7F, 8'hFF, 0, 0);
        chk("ovf_7f_ff", {54'd0, diff, borrow_out, overflow}, {54'd0, 8'h80, 1'b1, 1'b1});
        go8(8'h10, 8'h0F, 1, 1);
        chk("mid_start_ignored", {55'd0, diff, borrow_out}, 64'd0);

        // start held high: the second operation is accepted out of DONE
        a = 8'h33;
        b = 8'h11;
        bin = 0;
        start = 1;
        t1 = 0;
        t2 = 0;
        d1 = 0;
        d2 = 0;
        bo2 = 0;
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            if (t1 != 0 && n == t1 + 1) start = 0;
            if (done) begin
                if (t1 == 0) begin
                    t1 = n;
                    d1 = diff;
                    a = 8'h05;
                    b = 8'h09;
                    bin = 1;
                end else if (t2 == 0) begin
                    t2 = n;
                    d2 = diff;
                    bo2 = borrow_out;
                end
            end
        end
        chk("b2b_first_latency", 64'(t1 - 1), 64'd8);
        chk("b2b_spacing", 64'(t2 - t1), 64'd9);
        chk("b2b_first_diff", 64'(d1), 64'h22);
        chk("b2b_second_diff", {55'd0, d2, bo2}, {55'd0, 8'hFB, 1'b1});

        a = 8'hC3;
        b = 8'h21;
        bin = 0;
        start = 1;
        for (int n = 1; n <= 4; n++) begin
            @(negedge clk);
            start = 0;
        end
        rst = 1;
        #1;
        chk("async_reset", {59'd0, busy, done, borrow_out, overflow, |diff}, 64'd0);
        @(negedge clk);
        rst = 0;
        nd = 0;
        repeat (12) begin
            @(negedge clk);
            if (done || busy) nd = 1;
        end
        chk("no_done_after_reset", 64'(nd), 64'd0);
        go8(8'hC3, 8'h21, 0, 0);
        repeat (20) go8(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), int'($urandom_range(0, 1)), 0);

        go16(16'h1234, 16'h4321, 0);
        chk("diff_1234_4321", {46'd0, d16[2], bo16[2], ov16[2]}, {46'd0, 16'hCF13, 1'b1, 1'b0});
        go16(16'h0000, 16'hFFFF, 1);
        go16(16'hFFFF, 16'h0000, 0);
        go16(16'h8000, 16'h0000, 1);
        go16(16'h7FFF, 16'hFFFF, 0);
        repeat (1000) go16(int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)), int'($urandom_range(0, 1)));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Multi-cycle subtractor built around the team's full-subtractor cell, generalised to WIDTH-bit operands.
- Computes diff = a - b - borrow_in by processing BITS_PER_CYCLE bits per clock, LSB slice first, with a registered borrow chain between slices.
- Uses a start/busy/done handshake and reports borrow_out and signed overflow.
- Serves area-constrained datapaths where a full-width ripple subtractor is too large.

Parameters:
- WIDTH, 8, operand and result width in bits (>= 2).
- BITS_PER_CYCLE, 1, bits subtracted per clock. Must divide WIDTH exactly; otherwise a fatal elaboration error is raised.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request a new subtraction; sampled on the clk edge
- a  input  WIDTH  minuend; sampled only on an accepted start
- b  input  WIDTH  subtrahend; sampled only on an accepted start
- borrow_in  input  1  initial borrow; sampled only on an accepted start
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse: results valid and updated
- diff  output  WIDTH  result bits (a - b - borrow_in) mod 2^WIDTH
- borrow_out  output  1  borrow out of the MSB (high when unsigned a < b + borrow_in)
- overflow  output  1  two's-complement overflow: borrow into MSB XOR borrow out of MSB

Behaviour:
- Definitions: S = WIDTH / BITS_PER_CYCLE slices. Internal state: operand shift registers, borrow flop, slice counter, and a working result register separate from the diff output register.
- Reset (async assert, any state): FSM goes to IDLE; busy=0, done=0, diff=0, borrow_out=0, overflow=0; internal borrow and counter cleared. An in-flight operation is discarded and never produces done.
- IDLE state:
  - start=1 at an edge: latch a, b, borrow_in; counter=0; go to RUN; busy=1 from the next cycle.
  - start=0: stay in IDLE.
- RUN state, each edge:
  - Subtract slice k (bits k*BPC .. k*BPC+BPC-1) using the full-subtractor equations, rippling internally across BPC bits with the registered borrow as carry-in.
  - Store the slice result and the new borrow; k increments.
  - On the S-th RUN edge, also load diff, borrow_out and overflow from the completed computation, set done=1 and go to DONE.
  - overflow comes from the borrow entering the MSB bit and the borrow leaving it, both computed during the final slice.
- DONE state (one cycle): done=1, busy=0.
  - Next edge: done=0. If start=1 in this cycle, it is accepted (back-to-back) and the FSM goes to RUN; otherwise it goes to IDLE.
- Latency: start sampled at edge E0; done visible for exactly the one cycle after edge E_S (S cycles after the start edge). Throughput is one result per S+1 cycles.
- busy=1 exactly in RUN.
- diff, borrow_out and overflow change only on the edge that asserts done. They hold their previous values during RUN and until the next completion.
- start while in RUN is ignored; operands are not re-sampled.
- Input changes on a/b/borrow_in after the accepted start have no effect.
- Wrap-around: the result is always modulo 2^WIDTH; no saturation.
- BITS_PER_CYCLE=WIDTH: S=1; done is asserted one cycle after start.

Test Plan:
- WIDTH=8, BPC=1: a=8'h5A, b=8'h3C, bin=0, start pulse -> busy high 8 cycles, done on 8th cycle after start; diff=8'h1E, borrow_out=0, overflow=0.
- a=8'h00, b=8'h01, bin=0 -> diff=8'hFF, borrow_out=1, overflow=0.
- a=8'h80, b=8'h01 -> diff=8'h7F, borrow_out=0, overflow=1. Then a=8'h7F, b=8'hFF -> diff=8'h80, borrow_out=1, overflow=1.
- a=8'h10, b=8'h0F, bin=1 -> diff=8'h00, borrow_out=0. Pulse start again mid-RUN with other operands -> ignored; the same result is reported.
- Back-to-back: start held high through DONE -> second operation accepted; done pulses 9 cycles apart. Assert rst on RUN cycle 4 -> all outputs 0, no done; the next start completes normally.
- WIDTH=16, BPC=4: a=16'h1234, b=16'h4321 -> done 4 cycles after start; diff=16'hCF13, borrow_out=1, overflow=0. Compare against an a-b-bin reference over 1000 random vectors for BPC in {1,2,4,16}.
